change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Coin-return side of the vending controller. The accumulator FSM takes nickels and dimes in; this block pays change back out.
- Accepts a change request in nickel units over a valid/ready handshake.
- Drives a coin-ejector mechanism one coin at a time, dimes first and then nickels, each with a req/ack handshake.
- Tracks the dime and nickel inventory, which a refill port replenishes.

Parameters:
AMT_W, 4, width of change amount in nickel units (max 15 = 75c)
CNT_W, 8, width of each inventory counter
DIME_INIT, 4, dime count loaded at reset
NICKEL_INIT, 4, nickel count loaded at reset

Ports:
clk  input  1  clock, all logic on posedge
reset_n  input  1  synchronous, active-low reset
req_valid  input  1  change request valid
req_amount  input  AMT_W  change owed, nickel units
req_ready  output  1  block idle, request accepted when req_valid&req_ready
disp_dime  output  1  eject-one-dime request, held until disp_ack
disp_nickel  output  1  eject-one-nickel request, held until disp_ack
disp_ack  input  1  mechanism has ejected the requested coin
refill_dime  input  1  add one dime to inventory this cycle
refill_nickel  input  1  add one nickel to inventory this cycle
dime_count  output  CNT_W  current dime inventory
nickel_count  output  CNT_W  current nickel inventory
done  output  1  one-cycle pulse: request fully paid
err  output  1  one-cycle pulse: request rejected, insufficient coins

Behaviour:
- One clock, synchronous active-low reset.
- Reset (reset_n=0 at posedge):
  - state=IDLE, rem=0.
  - dime_count=DIME_INIT, nickel_count=NICKEL_INIT.
  - disp_dime=disp_nickel=done=err=0, req_ready=1 after reset.
- Reset mid-operation aborts the current request immediately. Coins already ejected are not restored.
- All outputs are Moore, decoded from registered state and counters.
- States: IDLE, CHECK, DIME, NICKEL, GAP, DONE, ERR.
- IDLE: req_ready=1. On accept, latch rem=req_amount and go to CHECK.
- CHECK (1 cycle, req_ready=0):
  - d_use = min(rem>>1, dime_count); n_need = rem - 2*d_use.
  - If n_need > nickel_count: go to ERR. No coins are dispensed and inventory is untouched.
  - Else if rem==0: go to DONE.
  - Else if rem>=2 and dime_count>0: go to DIME.
  - Else: go to NICKEL.
- DIME: disp_dime=1. On disp_ack: rem-=2, dime_count-=1, go to GAP.
- NICKEL: disp_nickel=1. On disp_ack: rem-=1, nickel_count-=1, go to GAP.
- GAP (1 cycle, both disp low):
  - Guarantees at least 1 low cycle between coins.
  - Next state: rem==0 → DONE; rem>=2 and dime_count>0 → DIME; else NICKEL.
- DONE: done=1 for one cycle, then IDLE. ERR: err=1 for one cycle, then IDLE.
- disp_dime and disp_nickel are never both high.
- disp_ack outside DIME/NICKEL is ignored.
- Ack latency is unbounded; the disp signal holds steady until ack.
- Latency:
  - Accept edge E0; CHECK during E0→E1.
  - First disp high from E1, or done/err high from E1.
  - Minimum per coin: 1 ack cycle + 1 GAP cycle.
- Inventory:
  - Refill increments by 1 and saturates at 2^CNT_W-1.
  - Refill in the same cycle as a decrement of the same coin leaves the count unchanged.
  - Decrement never occurs at 0; the CHECK guarantee holds because refills only increase counts.
- req_valid during non-IDLE is not accepted (req_ready=0). The requester holds it.

Test Plan:
- Reset with DIME_INIT=4, NICKEL_INIT=4 → dime_count=4, nickel_count=4, req_ready=1, disp_*/done/err=0.
- Request 3 (15c), ack each coin 1 cycle later → disp_dime once then disp_nickel once, with a low GAP cycle between; counts 3/3; done pulses 1 cycle; req_ready back to 1.
- Dimes=1, nickels=4, request 5 → 1 dime + 3 nickels in that order; counts 0/1; done pulse.
- Dimes=0, nickels=2, request 6 → err pulses at E1; no disp ever high; counts 0/2; request 0 → done at E1, no coins.
- Request 2, hold disp_ack low 5 cycles → disp_dime stays high 6 cycles. Assert refill_dime together with disp_ack → dime_count unchanged. Refill at count 255 → stays 255.
- Request 4, drop reset_n while disp_dime=1 → next edge state IDLE, disp_*=0, counts=INIT, req_ready=1; later ack ignored.

Source files
------------

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Coin-return side of the vending controller. Accepts a change request in
// nickel units over a valid/ready handshake and pays it out one coin at a
// time through a req/ack coin ejector: dimes first, then nickels. Keeps the
// dime and nickel inventory, which a refill port tops up.
//
// A request is checked against the inventory before any coin moves. If it
// cannot be paid in full it is rejected with an err pulse, and nothing is
// ejected.
//
// Ports:
//   clk           clock, all logic on posedge
//   reset_n       synchronous, active-low reset
//   req_valid     change request valid
//   req_amount    change owed, in nickel units
//   req_ready     block idle; request accepted when req_valid & req_ready
//   disp_dime     eject-one-dime request, held until disp_ack
//   disp_nickel   eject-one-nickel request, held until disp_ack
//   disp_ack      ejector has released the requested coin
//   refill_dime   add one dime to the inventory this cycle
//   refill_nickel add one nickel to the inventory this cycle
//   dime_count    current dime inventory
//   nickel_count  current nickel inventory
//   done          one-cycle pulse: request fully paid
//   err           one-cycle pulse: request rejected, not enough coins
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int AMT_W       = 4,
  parameter int CNT_W       = 8,
  parameter int DIME_INIT   = 4,
  parameter int NICKEL_INIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             disp_dime,
  output logic             disp_nickel,
  input  logic             disp_ack,
  input  logic             refill_dime,
  input  logic             refill_nickel,
  output logic [CNT_W-1:0] dime_count,
  output logic [CNT_W-1:0] nickel_count,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIME,
    S_NICKEL,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  // The feasibility check mixes the amount and the inventory widths, so it
  // is done in a width that holds either value without truncation.
  localparam int CHK_W = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] dime_q, dime_d;
  logic [CNT_W-1:0] nickel_q, nickel_d;

  logic             dime_dec, nickel_dec;
  logic             rem_zero, rem_ge2, use_dime;
  logic [CHK_W-1:0] half_rem, dimes_ext, nickels_ext, d_use, n_need;
  state_t           coin_state;

  // Returns the updated inventory count. A refill and a payout of the same
  // coin in one cycle cancel out. A refill on its own saturates at all-ones.
  // A payout never occurs at zero, because a request is only started when
  // the inventory covers it and refills only ever add coins.
  function automatic logic [CNT_W-1:0] inv_next(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             dec);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && dec) begin
      nxt = cnt;
    end else if (dec) begin
      nxt = cnt - CNT_W'(1);
    end else if (inc && (cnt != '1)) begin
      nxt = cnt + CNT_W'(1);
    end
    return nxt;
  endfunction

  // Feasibility check. Dimes are paid greedily, so the number of dimes used
  // is min(rem/2, dimes on hand). Whatever is left must come from nickels.
  always_comb begin
    half_rem    = CHK_W'(rem_q >> 1);
    dimes_ext   = CHK_W'(dime_q);
    nickels_ext = CHK_W'(nickel_q);
    d_use       = (half_rem < dimes_ext) ? half_rem : dimes_ext;
    n_need      = CHK_W'(rem_q) - (d_use << 1);
  end

  // Choice of the next coin. CHECK and GAP both make this same decision.
  assign rem_zero   = (rem_q == '0);
  assign rem_ge2    = |rem_q[AMT_W-1:1];
  assign use_dime   = rem_ge2 && (dime_q != '0);
  assign coin_state = rem_zero ? S_DONE : (use_dime ? S_DIME : S_NICKEL);

  // NOTE: every signal this block writes gets its default value first. A
  // path that leaves a combinational signal unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    dime_dec   = 1'b0;
    nickel_dec = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rem_d   = req_amount;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (n_need > nickels_ext) begin
          state_d = S_ERR;
        end else begin
          state_d = coin_state;
        end
      end
      S_DIME: begin
        if (disp_ack) begin
          rem_d    = rem_q - AMT_W'(2);
          dime_dec = 1'b1;
          state_d  = S_GAP;
        end
      end
      S_NICKEL: begin
        if (disp_ack) begin
          rem_d      = rem_q - AMT_W'(1);
          nickel_dec = 1'b1;
          state_d    = S_GAP;
        end
      end
      // GAP holds both eject lines low for one cycle between coins.
      S_GAP:   state_d = coin_state;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    dime_d   = inv_next(dime_q, refill_dime, dime_dec);
    nickel_d = inv_next(nickel_q, refill_nickel, nickel_dec);
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // updates from the values held before this clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      dime_q   <= CNT_W'(DIME_INIT);
      nickel_q <= CNT_W'(NICKEL_INIT);
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dime_q   <= dime_d;
      nickel_q <= nickel_d;
    end
  end

  // All outputs are decoded from registered state only.
  assign req_ready    = (state_q == S_IDLE);
  assign disp_dime    = (state_q == S_DIME);
  assign disp_nickel  = (state_q == S_NICKEL);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign dime_count   = dime_q;
  assign nickel_count = nickel_q;

endmodule
